// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter:
// op encodings and op field width.
package shifter_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_SLL = 2'b00;
    localparam logic [OP_W-1:0] OP_SRL = 2'b01;
    localparam logic [OP_W-1:0] OP_SRA = 2'b10;
    localparam logic [OP_W-1:0] OP_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: a single mux level
// shifting by 2**STAGE when cnt[STAGE] is set, plus the stage register.
// Ports: clk, rst_n, flush, adv_i (load enable), upstream bundle
// valid_i/data_i/op_i/cnt_i/tag_i, registered bundle *_o.
// PIPE_SHIFTER_ZERO_EN adds zero_o (registered zero flag, last stage only).
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    parameter int TAG_W = 4,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [TAG_W-1:0] tag_i,
`ifdef PIPE_SHIFTER_ZERO_EN
    output logic             zero_o,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [OP_W-1:0]  op_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int SH = 1 << STAGE;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [OP_W-1:0]  op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] tag_q;

    // Arithmetic shifts keep the MSB, so the current MSB is
    // always the original sign bit at every stage.
    always_comb begin
        data_d = data_i;
        if (cnt_i[STAGE]) begin
            unique case (op_i)
                OP_SLL:  data_d = data_i << SH;
                OP_SRL:  data_d = data_i >> SH;
                OP_SRA:  data_d = $signed(data_i) >>> SH;
                OP_ROR:  data_d = (data_i >> SH)
                                | (data_i << (WIDTH - SH));
                default: data_d = data_i;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (adv_i) begin
                valid_q <= valid_i;
            end
            if (adv_i) begin
                data_q <= data_d;
                op_q   <= op_i;
                cnt_q  <= cnt_i;
                tag_q  <= tag_i;
            end
        end
    end

`ifdef PIPE_SHIFTER_ZERO_EN
    if (STAGE == CNT_W - 1) begin : g_zero
        logic zero_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                zero_q <= 1'b0;
            end else if (adv_i) begin
                zero_q <= (data_d == '0);
            end
        end
        assign zero_o = zero_q;
    end else begin : g_nozero
        assign zero_o = 1'b0;
    end
`endif

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign op_o    = op_q;
    assign cnt_o   = cnt_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one mux level per stage,
// valid/ready on both sides with full backpressure and a sideband tag.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_data/in_cnt/in_op/in_tag;
// out_valid/out_ready/out_data/out_tag.
// PIPE_SHIFTER_ZERO_EN adds out_zero (registered out_data == 0).
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
`ifdef PIPE_SHIFTER_ZERO_EN
    output logic             out_zero,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Index 0 is the input side; index k+1 is the register of stage k.
    logic [CNT_W:0]   v;
    logic [CNT_W:0]   adv;
    logic [WIDTH-1:0] dat [CNT_W+1];
    logic [OP_W-1:0]  op  [CNT_W+1];
    logic [CNT_W-1:0] cnt [CNT_W+1];
    logic [TAG_W-1:0] tag [CNT_W+1];

`ifdef PIPE_SHIFTER_ZERO_EN
    logic [CNT_W-1:0] zero_w;
    assign out_zero = zero_w[CNT_W-1];
`endif

    assign v[0]   = in_valid;
    assign dat[0] = in_data;
    assign op[0]  = in_op;
    assign cnt[0] = in_cnt;
    assign tag[0] = in_tag;

    // A stage loads when it is empty or its successor loads.
    always_comb begin
        adv = '0;
        adv[CNT_W] = !v[CNT_W] || out_ready;
        for (int k = CNT_W - 1; k >= 0; k--) begin
            adv[k] = !v[k+1] || adv[k+1];
        end
    end

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W),
            .TAG_W (TAG_W),
            .STAGE (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .adv_i   (adv[k]),
            .valid_i (v[k]),
            .data_i  (dat[k]),
            .op_i    (op[k]),
            .cnt_i   (cnt[k]),
            .tag_i   (tag[k]),
`ifdef PIPE_SHIFTER_ZERO_EN
            .zero_o  (zero_w[k]),
`endif
            .valid_o (v[k+1]),
            .data_o  (dat[k+1]),
            .op_o    (op[k+1]),
            .cnt_o   (cnt[k+1]),
            .tag_o   (tag[k+1])
        );
    end

    assign in_ready  = adv[0];
    assign out_valid = v[CNT_W];
    assign out_data  = dat[CNT_W];
    assign out_tag   = tag[CNT_W];

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (WIDTH=16): directed ops, latency,
// backpressure, streaming, flush and mid-stream reset.
module tb_pipe_shifter;
    import shifter_pkg::*;

    localparam int W  = 16;
    localparam int CW = 4;
    localparam int TW = 4;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [CW-1:0] in_cnt;
    logic [1:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
`ifdef PIPE_SHIFTER_ZERO_EN
    logic          out_zero;
`endif

    exp_t sb[$];
    exp_t nxt_exp;
    int   n_chk  = 0;
    int   n_fail = 0;

    pipe_shifter #(.WIDTH(W), .CNT_W(CW), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .in_tag    (in_tag),
`ifdef PIPE_SHIFTER_ZERO_EN
        .out_zero  (out_zero),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(
        input logic [1:0] op, input logic [W-1:0] d, input int c);
        logic [2*W-1:0] t;
        case (op)
            OP_SLL:  ref_shift = d << c;
            OP_SRL:  ref_shift = d >> c;
            OP_SRA: begin
                t = {{W{d[W-1]}}, d} >> c;
                ref_shift = t[W-1:0];
            end
            default: begin
                t = {d, d} >> c;
                ref_shift = t[W-1:0];
            end
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [W-1:0] d,
                         input int c, input logic [TW-1:0] t,
                         input logic [W-1:0] e);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_cnt   = CW'(c);
        in_tag   = t;
        nxt_exp  = '{data: e, tag: t};
    endtask

    task automatic drive_rand(input logic [TW-1:0] t);
        logic [1:0]   op;
        logic [W-1:0] d;
        int           c;
        op = 2'($urandom_range(0, 3));
        d  = W'($urandom);
        c  = $urandom_range(0, W - 1);
        drive(op, d, c, t, ref_shift(op, d, c));
    endtask

    // Called just after a falling edge with inputs set for this cycle.
    task automatic cyc(output bit acc, output bit emt);
        exp_t e;
        #1;
        emt = out_valid && out_ready;
        acc = in_valid && in_ready && !flush;
        if (emt) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("data", 32'(out_data), 32'(e.data));
                check("tag", 32'(out_tag), 32'(e.tag));
`ifdef PIPE_SHIFTER_ZERO_EN
                check("zero", 32'(out_zero), 32'(e.data == '0));
`endif
            end
        end
        if (acc) sb.push_back(nxt_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        bit a, e;
        cyc(a, e);
    endtask

    task automatic run_one(input logic [1:0] op, input logic [W-1:0] d,
                           input int c, input logic [TW-1:0] t,
                           input logic [W-1:0] e);
        bit a, m;
        int lat;
        drive(op, d, c, t, e);
        cyc(a, m);
        check("accept", 32'(a), 1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        check("latency", lat, CW);
        tick();
    endtask

    initial begin
        bit acc, emt;
        int idx, gaps, n_acc;
        logic [W-1:0]  hold_d;
        logic [TW-1:0] hold_t;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_cnt = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1; nxt_exp = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_tag", 32'(out_tag), 0);
`ifdef PIPE_SHIFTER_ZERO_EN
        check("rst_zero", 32'(out_zero), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        // Directed ops, each with latency check
        run_one(OP_SLL, 16'h0001, 15, 4'h1, 16'h8000);
        run_one(OP_SRL, 16'hF000, 12, 4'h2, 16'h000F);
        run_one(OP_SRA, 16'h8000, 15, 4'h3, 16'hFFFF);
        run_one(OP_SRA, 16'h7000, 4, 4'h4, 16'h0700);
        run_one(OP_ROR, 16'h1234, 4, 4'h5, 16'h4123);
        for (int o = 0; o < 4; o++) begin
            run_one(2'(o), 16'hA5C3, 0, 4'(6 + o), 16'hA5C3);
        end
`ifdef PIPE_SHIFTER_ZERO_EN
        run_one(OP_SRL, 16'h000F, 4, 4'hA, 16'h0000);
`endif

        // Backpressure: 6 ops with the consumer stalled
        out_ready = 1'b0;
        idx = 0;
        hold_d = '0;
        hold_t = '0;
        for (int i = 0; i < 10; i++) begin
            if (idx < 6) drive_rand(4'(idx));
            else in_valid = 1'b0;
            if (i == 6) begin
                hold_d = out_data;
                hold_t = out_tag;
            end
            cyc(acc, emt);
            if (acc) idx++;
        end
        check("bp_accepts", idx, 4);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_valid", 32'(out_valid), 1);
        check("bp_hold_data", 32'(out_data), 32'(hold_d));
        check("bp_hold_tag", 32'(out_tag), 32'(hold_t));
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (idx >= 6 && sb.size() == 0) break;
            if (idx < 6) drive_rand(4'(idx));
            else in_valid = 1'b0;
            cyc(acc, emt);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_in", idx, 6);
        check("bp_drained", sb.size(), 0);

        // Streaming: full rate, one result per cycle after the fill
        n_acc = 0;
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            drive_rand(4'(i));
            cyc(acc, emt);
            if (acc) n_acc++;
            if (i >= CW && !emt) gaps++;
        end
        in_valid = 1'b0;
        check("st_accepts", n_acc, 100);
        check("st_gaps", gaps, 0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("st_drained", sb.size(), 0);

        // Flush with three ops in flight
        for (int i = 0; i < 3; i++) begin
            drive_rand(4'(i));
            tick();
        end
        drive_rand(4'hE);
        flush = 1'b1;
        cyc(acc, emt);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_no_accept", 32'(acc), 0);
        check("fl_out_valid", 32'(out_valid), 0);
        sb.delete();
        gaps = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) gaps++;
            tick();
        end
        check("fl_quiet", gaps, 0);
        run_one(OP_SLL, 16'h0003, 2, 4'h9, 16'h000C);

        // Reset in the middle of a stream
        for (int i = 0; i < 6; i++) begin
            drive_rand(4'(i + 3));
            tick();
        end
        check("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_tag", 32'(out_tag), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 1);
        @(negedge clk);
        run_one(OP_ROR, 16'h8001, 1, 4'hB, 16'hC000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
